// File: rtl/multiplier_sequencer.sv
// 32x32 unsigned shift-add multiplier: one time-shared 32-bit ripple adder,
// 32 iterations per product, valid/ready handshakes on both sides.
module multiplier_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   acc_hi, acc_hi_nxt;
  logic [W-1:0]   acc_lo, acc_lo_nxt;
  logic [W-1:0]   mcand_reg, mcand_nxt;
  logic [CW-1:0]  count, count_nxt;

  logic [W-1:0]   addend;
  logic [W-1:0]   sum;
  logic [W:0]     chain;
  logic           carry;

  // Ripple-carry adder, carry-in tied low; carry-out becomes the new acc MSB.
  always_comb begin
    addend   = acc_lo[0] ? mcand_reg : '0;
    chain    = '0;
    chain[0] = 1'b0;
    sum      = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum[i]       = acc_hi[i] ^ addend[i] ^ chain[i];
      chain[i + 1] = (acc_hi[i] & addend[i]) | (chain[i] & (acc_hi[i] ^ addend[i]));
    end
    carry = chain[W];
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state;
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    mcand_nxt  = mcand_reg;
    count_nxt  = count;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_hi_nxt = '0;
          acc_lo_nxt = multiplier;
          mcand_nxt  = multiplicand;
          count_nxt  = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        {acc_hi_nxt, acc_lo_nxt} = {carry, sum, acc_lo[W-1:1]};
        count_nxt = count + CW'(1);
        if (count == CW'(W - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_hi    <= '0;
      acc_lo    <= '0;
      mcand_reg <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      acc_hi    <= acc_hi_nxt;
      acc_lo    <= acc_lo_nxt;
      mcand_reg <= mcand_nxt;
      count     <= count_nxt;
    end
  end

  // Status outputs are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = {acc_hi, acc_lo};

endmodule

// File: doc/multiplier_sequencer.md
MULTIPLIER_SEQUENCER -- requirements
Module: multiplier_sequencer

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  request: operands present.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 multiplicand  input  32  unsigned operand A.
REQ-007 multiplier  input  32  unsigned operand B.
REQ-008 out_valid  output  1  product available.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  64  unsigned A*B.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The block SHALL use one 32-bit ripple adder per cycle, with carry_in tied to 0, time-shared across 32 iterations (shift-add).
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL equal not-IDLE.
REQ-015 Acceptance occurs on an edge where in_valid=1 in IDLE. On acceptance: acc_hi<=0, acc_lo<=multiplier, mcand_reg<=multiplicand, count<=0, and IDLE->RUN.
REQ-016 Each RUN edge: sum,carry = acc_hi + (acc_lo[0] ? mcand_reg : 0); {acc_hi,acc_lo} <= {carry,sum,acc_lo[31:1]}; count<=count+1.
REQ-017 The 6-bit count SHALL leave RUN for DONE on the edge performing iteration 32 (count==31 before the edge); exactly 32 iterations, no early termination.
REQ-018 Latency: if acceptance is at edge E0, out_valid SHALL rise after E32 and stay 1 until the handshake.
REQ-019 product SHALL equal {acc_hi,acc_lo}. Its value is defined only while out_valid=1 and SHALL stay stable throughout DONE.
REQ-020 In DONE, an edge with out_ready=1 SHALL move the FSM to IDLE. Otherwise it SHALL hold DONE indefinitely (backpressure).
REQ-021 A new request SHALL NOT be accepted in the same cycle as the DONE handshake; in_ready rises the cycle after. Minimum request spacing is 34 cycles.
REQ-022 in_valid, multiplicand and multiplier SHALL be ignored outside IDLE. Operand changes during RUN or DONE SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 The adder carry_out SHALL never be dropped: the full 64-bit product is exact for all inputs and no overflow is possible.

Reset
REQ-025 On any edge with rst=1, the FSM SHALL go to IDLE and acc_hi, acc_lo, mcand_reg and count SHALL clear to 0, regardless of state.
REQ-026 After reset: in_ready=1, out_valid=0, busy=0, product=0.
REQ-027 Reset mid-RUN or mid-DONE SHALL abandon the operation; no out_valid pulse follows.
REQ-028 rst SHALL take priority over a simultaneous in_valid or out_ready.

Verification
REQ-029 A=3, B=5, out_ready=1 -> product=0x0000_0000_0000_000F; out_valid first high 32 cycles after the acceptance edge, for one cycle.
REQ-030 A=0xFFFF_FFFF, B=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001 (carry path exercised).
REQ-031 A=0x8000_0000, B=2 -> product=0x0000_0001_0000_0000. Then A=0, B=0x1234_5678 -> product=0.
REQ-032 out_ready held 0 for 10 cycles after out_valid rises -> out_valid and product stay constant. Drop out_ready to 1 -> IDLE next edge, in_ready=1.
REQ-033 Accept A=7, B=9; change the operands and pulse in_valid during RUN -> product=63, one result only, in_ready=0 throughout.
REQ-034 rst=1 on RUN iteration 10 -> next cycle in_ready=1, busy=0, out_valid=0. A fresh request A=6, B=7 -> 42 with full 32-cycle latency.
